// File: rtl/knn_pkg.sv
// Shared defaults, derived widths and FSM encoding for the KNN neighbour list.
// The top derives its own distance width from its W parameter; DIST_W/DIST_INF describe the defaults.
package knn_pkg;

  localparam int DEF_W      = 32;
  localparam int DEF_K      = 10;
  localparam int DEF_LBL_W  = 8;
  localparam int DEF_NCLASS = 4;

  localparam int DIST_W = DEF_W + 1;
  localparam logic [DIST_W-1:0] DIST_INF = {DIST_W{1'b1}};

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    VOTE    = 2'd1,
    DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/knn_label_count.sv
// Counts how many occupied slots of the neighbour list carry a given class label.
module knn_label_count #(
  parameter int K     = 10,
  parameter int LBL_W = 8,
  parameter int CNT_W = 4
) (
  input  logic [K-1:0][LBL_W-1:0] labels,
  input  logic [K-1:0]            occ,
  input  logic [LBL_W-1:0]        cls,
  output logic [CNT_W-1:0]        n
);

  always_comb begin
    n = '0;
    for (int i = 0; i < K; i++) begin
      if (occ[i] && (labels[i] == cls)) begin
        n = n + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/knn_neighbor_list.sv
// Sorted list of the K nearest training points plus a class-by-class majority vote.
// Occupied slots always form a prefix of the list, so occupancy is derived from count.
module knn_neighbor_list
  import knn_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int K      = DEF_K,
  parameter int LBL_W  = DEF_LBL_W,
  parameter int NCLASS = DEF_NCLASS,
  localparam int DW    = W + 1,
  localparam int IDX_W = (K > 1) ? $clog2(K) : 1,
  localparam int CNT_W = $clog2(K + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             valid,
  input  logic [DW-1:0]    dist_in,
  input  logic [LBL_W-1:0] label_in,
  input  logic             last,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [DW-1:0]    rd_dist,
  output logic [LBL_W-1:0] rd_label,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [LBL_W-1:0] vote_label
);

  localparam logic [DW-1:0] INF = {DW{1'b1}};

  state_t                  state;
  logic [K-1:0][DW-1:0]    slot_dist;
  logic [K-1:0][LBL_W-1:0] slot_label;
  logic [K-1:0][DW-1:0]    nxt_dist;
  logic [K-1:0][LBL_W-1:0] nxt_label;
  logic [K-1:0]            occ;
  logic [K-1:0]            le;
  logic [LBL_W-1:0]        cls;
  logic [LBL_W-1:0]        best_label;
  logic [CNT_W-1:0]        best_cnt;
  logic [CNT_W-1:0]        n_cls;

  // le is a prefix mask: slots whose entry stays in place ahead of the new sample.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      occ[i] = (count > CNT_W'(i));
      le[i]  = occ[i] && (slot_dist[i] <= dist_in);
    end
  end

  // The first slot not in the prefix takes the new sample; every later slot takes its predecessor.
  always_comb begin
    nxt_dist  = slot_dist;
    nxt_label = slot_label;
    if (!le[0]) begin
      nxt_dist[0]  = dist_in;
      nxt_label[0] = label_in;
    end
    for (int i = 1; i < K; i++) begin
      if (!le[i]) begin
        nxt_dist[i]  = le[i-1] ? dist_in  : slot_dist[i-1];
        nxt_label[i] = le[i-1] ? label_in : slot_label[i-1];
      end
    end
  end

  always_comb begin
    rd_dist  = INF;
    rd_label = '0;
    if (32'(rd_idx) < K) begin
      rd_dist  = slot_dist[rd_idx];
      rd_label = slot_label[rd_idx];
    end
  end

  knn_label_count #(
    .K     (K),
    .LBL_W (LBL_W),
    .CNT_W (CNT_W)
  ) u_label_count (
    .labels (slot_label),
    .occ    (occ),
    .cls    (cls),
    .n      (n_cls)
  );

  // Collect inserts, then sweep one class per cycle keeping the first strict maximum.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state      <= COLLECT;
      slot_dist  <= {K{INF}};
      slot_label <= '0;
      count      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      vote_label <= '0;
      cls        <= '0;
      best_label <= '0;
      best_cnt   <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (valid) begin
            slot_dist  <= nxt_dist;
            slot_label <= nxt_label;
            if (count < CNT_W'(K)) begin
              count <= count + CNT_W'(1);
            end
            if (last) begin
              state      <= VOTE;
              busy       <= 1'b1;
              cls        <= '0;
              best_label <= '0;
              best_cnt   <= '0;
            end
          end
        end
        VOTE: begin
          if (n_cls > best_cnt) begin
            best_label <= cls;
            best_cnt   <= n_cls;
          end
          if (cls == LBL_W'(NCLASS - 1)) begin
            state      <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            vote_label <= (n_cls > best_cnt) ? cls : best_label;
          end else begin
            cls <= cls + LBL_W'(1);
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= COLLECT;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
